// File: rtl/spdif_sample_feeder.sv
// Stereo frame FIFO feeding the S/PDIF transmitter.
// Serves per-channel pop edges with a one-cycle ack; mutes and flags on underrun.
module spdif_sample_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int SAMPLE_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_i,
    input  logic [2*SAMPLE_W-1:0]   wr_data_i,
    output logic                    full_o,
    output logic [DEPTH_LOG2:0]     level_o,
    input  logic [1:0]              pop_i,
    output logic [1:0]              ack_o,
    output logic [2*SAMPLE_W-1:0]   data_o,
    output logic                    underrun_o,
    output logic                    overflow_o,
    input  logic                    clr_flags_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = 2 * SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_L,
        SERVE_R
    } state_e;

    logic [FW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]            pop_q;
    logic [1:0]            pop_prev_q;
    logic [1:0]            pop_edge;
    logic                  pend_r_q, pend_r_d;
    logic                  left_taken_q, left_taken_d;
    state_e                state_q, state_d;
    logic [SAMPLE_W-1:0]   data_l_q, data_l_d;
    logic [SAMPLE_W-1:0]   data_r_q, data_r_d;
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;

    logic                  empty;
    logic                  full;
    logic [FW-1:0]         head;
    logic                  want_l;
    logic                  want_r;
    logic                  serve_l;
    logic                  serve_r;
    logic                  head_adv;
    logic                  pop_empty;
    logic                  wr_acc;
    logic                  wr_drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign pop_edge = pop_q & ~pop_prev_q;
    assign want_l   = pop_edge[0];
    assign want_r   = pop_edge[1] | pend_r_q;
    // Left wins a tie; a held-off right request waits in pend_r.
    assign serve_l  = want_l;
    assign serve_r  = want_r & ~want_l;

    // Read FSM: choose the half to serve and load the output half.
    always_comb begin
        state_d      = IDLE;
        pend_r_d     = pend_r_q;
        left_taken_d = left_taken_q;
        data_l_d     = data_l_q;
        data_r_d     = data_r_q;
        head_adv     = 1'b0;
        pop_empty    = 1'b0;
        unique case (1'b1)
            serve_l: begin
                state_d      = SERVE_L;
                pend_r_d     = want_r;
                data_l_d     = empty ? '0 : head[FW-1:SAMPLE_W];
                left_taken_d = 1'b1;
                pop_empty    = empty;
            end
            serve_r: begin
                state_d      = SERVE_R;
                pend_r_d     = 1'b0;
                data_r_d     = empty ? '0 : head[SAMPLE_W-1:0];
                left_taken_d = 1'b0;
                head_adv     = ~empty;
                pop_empty    = empty;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer and sticky-flag next state; a head advance frees a slot for a write.
    always_comb begin
        wr_acc     = wr_i & (~full | head_adv);
        wr_drop    = wr_i & ~wr_acc;
        wr_ptr_d   = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, wr_acc};
        rd_ptr_d   = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, head_adv};
        underrun_d = pop_empty | (underrun_q & ~clr_flags_i);
        overflow_d = wr_drop | (overflow_q & ~clr_flags_i);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pop_q        <= '0;
            pop_prev_q   <= '0;
            pend_r_q     <= 1'b0;
            left_taken_q <= 1'b0;
            state_q      <= IDLE;
            data_l_q     <= '0;
            data_r_q     <= '0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pop_q        <= pop_i;
            pop_prev_q   <= pop_q;
            pend_r_q     <= pend_r_d;
            left_taken_q <= left_taken_d;
            state_q      <= state_d;
            data_l_q     <= data_l_d;
            data_r_q     <= data_r_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    // Frame storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
        end
    end

    // A left serve always leaves the left-taken marker set.
    a_left_taken: assert property (
        @(posedge clk) disable iff (!rst)
        (state_q == SERVE_L) |-> left_taken_q
    );

    assign full_o     = full;
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign ack_o      = {state_q == SERVE_L, state_q == SERVE_R};
    assign data_o     = {data_l_q, data_r_q};
    assign underrun_o = underrun_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_spdif_sample_feeder.sv
// Scoreboard bench for spdif_sample_feeder.
// Directed pops push expected acks; a negedge monitor checks them.
module tb_spdif_sample_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_i = 1'b0;
    logic [47:0] wr_data = '0;
    logic        full_o;
    logic [4:0]  level_o;
    logic [1:0]  pop = 2'b00;
    logic [1:0]  ack_o;
    logic [47:0] data_o;
    logic        underrun_o;
    logic        overflow_o;
    logic        clr = 1'b0;

    spdif_sample_feeder #(.DEPTH_LOG2(4), .SAMPLE_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (wr_i),
        .wr_data_i   (wr_data),
        .full_o      (full_o),
        .level_o     (level_o),
        .pop_i       (pop),
        .ack_o       (ack_o),
        .data_o      (data_o),
        .underrun_o  (underrun_o),
        .overflow_o  (overflow_o),
        .clr_flags_i (clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  ack;
        logic [23:0] half;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [47:0] f);
        wr_i = 1'b1;
        wr_data = f;
        tick();
        wr_i = 1'b0;
    endtask

    task automatic expect_ack(input logic [1:0] a, input logic [23:0] h,
                              input int due);
        exp_t e;
        e.ack = a;
        e.half = h;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic pop1(input int ch, input logic [23:0] h);
        expect_ack((ch == 0) ? 2'b10 : 2'b01, h, cyc + 2);
        pop[ch] = 1'b1;
        tick();
        pop = 2'b00;
        repeat (3) tick();
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [47:0] fr(input int i);
        return {8'h10, i[15:0], 8'h20, i[15:0]};
    endfunction

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ack_o != 2'b00) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got %b want none", ack_o);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_bits", {46'd0, ack_o}, {46'd0, mon_e.ack});
                chk("ack_data",
                    {24'd0, ack_o[1] ? data_o[47:24] : data_o[23:0]},
                    {24'd0, mon_e.half});
                chk("ack_cycle", 48'(cyc), 48'(mon_e.due));
            end
        end
    end

    int c;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_level", 48'(level_o), 48'd0);
        chk("rst_full", 48'(full_o), 48'd0);
        chk("rst_ack", 48'(ack_o), 48'd0);
        chk("rst_data", data_o, 48'd0);
        chk("rst_flags", {46'd0, underrun_o, overflow_o}, 48'd0);
        rst = 1'b1;
        tick();

        // Basic L/R sequence
        wr(48'h000001_ABCDEF);
        wr(48'h000002_ABCDEF);
        chk("lvl_2", 48'(level_o), 48'd2);
        pop1(0, 24'h000001);
        chk("lvl_after_L", 48'(level_o), 48'd2);
        pop1(1, 24'hABCDEF);
        chk("lvl_after_R", 48'(level_o), 48'd1);
        pop1(0, 24'h000002);
        pop1(1, 24'hABCDEF);
        chk("lvl_0", 48'(level_o), 48'd0);
        chk("data_hold", data_o, 48'h000002_ABCDEF);

        // Fill and overflow
        for (int i = 0; i < 16; i++) wr(fr(i));
        chk("full", 48'(full_o), 48'd1);
        chk("lvl_16", 48'(level_o), 48'd16);
        chk("no_ovf_yet", 48'(overflow_o), 48'd0);
        wr(48'hBAD000_BAD000);
        chk("ovf_set", 48'(overflow_o), 48'd1);
        chk("lvl_16_drop", 48'(level_o), 48'd16);
        clr_pulse();
        chk("ovf_clr", 48'(overflow_o), 48'd0);

        // Write on a full FIFO coincident with the head advance
        pop1(0, fr(0) >> 24);
        c = cyc;
        expect_ack(2'b01, fr(0) & 48'hFFFFFF, c + 2);
        pop[1] = 1'b1;
        tick();
        pop = 2'b00;
        wr_i = 1'b1;
        wr_data = 48'h0FF1CE_C0FFEE;
        tick();
        wr_i = 1'b0;
        chk("coinc_lvl", 48'(level_o), 48'd16);
        chk("coinc_ovf", 48'(overflow_o), 48'd0);
        chk("coinc_full", 48'(full_o), 48'd1);
        repeat (3) tick();

        // Drain through the wrap
        for (int i = 1; i < 16; i++) begin
            pop1(0, fr(i) >> 24);
            pop1(1, fr(i) & 48'hFFFFFF);
        end
        pop1(0, 24'h0FF1CE);
        pop1(1, 24'hC0FFEE);
        chk("drained_lvl", 48'(level_o), 48'd0);
        chk("drained_urun", 48'(underrun_o), 48'd0);

        // Underrun on empty
        pop1(0, 24'h0);
        pop1(1, 24'h0);
        chk("urun_set", 48'(underrun_o), 48'd1);
        chk("urun_data", data_o, 48'd0);
        chk("urun_lvl", 48'(level_o), 48'd0);
        clr_pulse();
        chk("urun_clr", 48'(underrun_o), 48'd0);

        // Clear coincident with a new underrun: event wins
        c = cyc;
        expect_ack(2'b01, 24'h0, c + 2);
        pop[1] = 1'b1;
        tick();
        pop = 2'b00;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("clr_vs_evt", 48'(underrun_o), 48'd1);
        repeat (2) tick();
        clr_pulse();
        chk("urun_clr2", 48'(underrun_o), 48'd0);

        // Simultaneous L and R edges
        wr(48'h123456_789ABC);
        c = cyc;
        expect_ack(2'b10, 24'h123456, c + 2);
        expect_ack(2'b01, 24'h789ABC, c + 3);
        pop = 2'b11;
        tick();
        pop = 2'b00;
        repeat (4) tick();
        chk("both_lvl", 48'(level_o), 48'd0);
        chk("both_data", data_o, 48'h123456_789ABC);

        // Reset between pop edge and its ack
        wr(48'h0A0B0C_0D0E0F);
        pop[0] = 1'b1;
        tick();
        pop = 2'b00;
        rst = 1'b0;
        tick();
        tick();
        chk("mid_ack", 48'(ack_o), 48'd0);
        chk("mid_data", data_o, 48'd0);
        chk("mid_lvl", 48'(level_o), 48'd0);
        chk("mid_flags", {46'd0, underrun_o, overflow_o}, 48'd0);
        rst = 1'b1;
        tick();
        wr(48'h777777_888888);
        pop1(0, 24'h777777);
        pop1(1, 24'h888888);
        chk("post_lvl", 48'(level_o), 48'd0);

        repeat (4) tick();
        chk("sb_drained", 48'(sb.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
